pgm_ddram_arbiter: RTL and testbench
====================================

// Module: pgm_ddram_arbiter
// PURPOSE
//  Shares the single DDRAM Avalon read/write port between one ROM-load writer (ioctl download path)
//  and three word readers (0=CPU program ROM, 1=video tile/sprite ROM, 2=sound sample ROM).
//  Serialises one 64-bit, burst-length-1 transaction at a time and returns read data with a one-cycle ack.
//  Sits between the PGM core / video fetchers and the emu-level DDRAM_* pins, in the clk_sys domain.
// PARAMETERS
//  AW         25            requester word-address width (64-bit words)
//  BASE_WADDR 29'h0600_0000 DDRAM word address added to every requester address
//  TIMEOUT    1023          max cycles in RD_WAIT before forced completion
// PORTS
//  clk              in  1     system clock; all logic on rising edge
//  reset            in  1     synchronous, active-high
//  wr_req           in  1     write request, level; wr_addr/wr_data/wr_be stable while high
//  wr_addr          in  AW    write word address
//  wr_data          in  64    write data
//  wr_be            in  8     write byte enables
//  wr_ack           out 1     1-cycle pulse: write accepted by DDRAM
//  rd_req           in  3     per-reader request, level; rd_addr slice stable while high
//  rd_addr          in  3*AW  reader i address = rd_addr[i*AW +: AW]
//  rd_ack           out 3     1-cycle pulse, one-hot; rd_data valid in same cycle
//  rd_data          out 64    read data, held until next ack
//  err              out 1     sticky: a read timed out
//  ddram_busy       in  1     Avalon waitrequest
//  ddram_dout       in  64    read data
//  ddram_dout_ready in  1     read data valid
//  ddram_addr       out 29    BASE_WADDR + zero-extended address, modulo 2^29 (wraps, no error)
//  ddram_burstcnt   out 4     constant 4'd1
//  ddram_rd         out 1     read command
//  ddram_we         out 1     write command
//  ddram_din        out 64    write data (latched at grant)
//  ddram_be         out 8     byte enables (latched at grant)
// BEHAVIOUR
//  Reset: state IDLE, rr pointer 0, wr_ack/rd_ack/ddram_rd/ddram_we/err = 0, rd_data/ddram_addr/din/be = 0.
//  All outputs are registered. States: IDLE, WR, RD_CMD, RD_WAIT.
//  IDLE: eligible reader i = rd_req[i] & ~rd_ack[i] (masks the requester still high in its ack cycle).
//   Order: wr_req (if ~wr_ack) wins -> latch addr/din/be, ddram_we=1, go WR.
//   Otherwise round-robin among eligible readers starting at rr: grant g, latch addr,
//   ddram_rd=1, rr <= (g+1) mod 3, go RD_CMD. No request: stay IDLE.
//  WR: command held while ddram_busy=1; on edge with busy=0: ddram_we=0, wr_ack=1, go IDLE.
//  RD_CMD: held while busy=1; on edge with busy=0: ddram_rd=0, clear timer, go RD_WAIT.
//  RD_WAIT: on ddram_dout_ready: rd_data<=ddram_dout, rd_ack[g]=1, go IDLE.
//   Timer reaches TIMEOUT first: rd_data<=64'hFFFF_FFFF_FFFF_FFFF, rd_ack[g]=1, err=1, go IDLE.
//  ddram_dout_ready outside RD_WAIT is discarded, no state change.
//  Latency (busy=0, data after N cycles): grant->ddram_rd 1 cycle, rd_ack 1 cycle after dout_ready.
//   Min req->ack = N+3 cycles.
//  Requester dropping req before ack: transaction still completes, ack still pulses (ignored by requester).
//  Reset mid-transaction: immediate return to reset values; no ack for the aborted transaction.
//  Simultaneous wr_req and rd_req: write first; readers served strictly after.
//  Fairness: no reader waits more than 2 read grants plus pending writes.
// CONFIGURATION
//  PGM_DDR_LASTHIT_EN defined: per-reader 1-entry cache {valid, addr, data} filled on every non-error read ack.
//   In IDLE, before arbitration, if an eligible reader's addr matches its valid entry:
//   rd_ack[i]=1 with cached data next cycle, no DDRAM access, rr unchanged.
//   Lowest index first if several hit. Any accepted write or reset clears all valid bits.
//  Not defined: no cache; every read goes to DDRAM.
// TESTING
//  1 Reset then rd_req=3'b001, addr 0x10, busy=0, dout_ready 4 cycles later with 0x1122334455667788
//    -> ddram_addr=0x0600_0010, rd_ack=001, rd_data=0x1122334455667788.
//  2 rd_req=3'b111 held for 6 grants -> grant order 0,1,2,0,1,2; each ack one-hot.
//  3 wr_req and rd_req[1] same cycle, busy high 3 cycles
//    -> ddram_we held 4 cycles, wr_ack, then reader 1 served; din/be match latched values.
//  4 Read with no dout_ready -> rd_ack after TIMEOUT cycles, rd_data all ones, err=1 until reset.
//  5 Assert reset during RD_WAIT, then send late dout_ready -> no ack, all outputs 0, next read correct.
//  6 (PGM_DDR_LASTHIT_EN) repeat same addr on reader 2 -> ack 1 cycle after req, no ddram_rd;
//    after a write, same addr -> DDRAM read issued.

Source files
------------

// File: rtl/pgm_ddram_arbiter.sv
// pgm_ddram_arbiter
// Shares the single 64-bit DDRAM Avalon port between one ROM-load writer and three
// word readers (0 = CPU program ROM, 1 = video tile/sprite ROM, 2 = sound sample ROM).
// One burst-length-1 transaction is in flight at a time; read data comes back with a
// one-cycle, one-hot ack. All outputs are registered. Lives in the clk_sys domain.
//
// Ports:
//   clk_i, reset_i          clock, synchronous active-high reset
//   wr_req_i/wr_addr_i/     level write request with word address, data, byte enables
//   wr_data_i/wr_be_i
//   wr_ack_o                1-cycle pulse when DDRAM accepted the write
//   rd_req_i[2:0]           per-reader level request
//   rd_addr_i[3*AW-1:0]     reader i address = rd_addr_i[i*AW +: AW]
//   rd_ack_o[2:0]           1-cycle one-hot ack, rd_data_o valid in the same cycle
//   rd_data_o               read data, held until the next ack
//   err_o                   sticky flag: a read timed out
//   ddram_*                 Avalon master side (busy = waitrequest)
//
// Optional feature: define PGM_DDR_LASTHIT_EN to add a per-reader one-entry
// last-hit cache that answers repeated reads of the same address without DDRAM.
module pgm_ddram_arbiter #(
    parameter int          AW         = 25,
    parameter logic [28:0] BASE_WADDR = 29'h0600_0000,
    parameter int          TIMEOUT    = 1023
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            wr_req_i,
    input  logic [AW-1:0]   wr_addr_i,
    input  logic [63:0]     wr_data_i,
    input  logic [7:0]      wr_be_i,
    output logic            wr_ack_o,
    input  logic [2:0]      rd_req_i,
    input  logic [3*AW-1:0] rd_addr_i,
    output logic [2:0]      rd_ack_o,
    output logic [63:0]     rd_data_o,
    output logic            err_o,
    input  logic            ddram_busy_i,
    input  logic [63:0]     ddram_dout_i,
    input  logic            ddram_dout_ready_i,
    output logic [28:0]     ddram_addr_o,
    output logic [3:0]      ddram_burstcnt_o,
    output logic            ddram_rd_o,
    output logic            ddram_we_o,
    output logic [63:0]     ddram_din_o,
    output logic [7:0]      ddram_be_o
);

    localparam int            TW           = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, WR, RD_CMD, RD_WAIT} state_t;

    state_t        state_q;
    logic [1:0]    rrPtr_q;
    logic [1:0]    grant_q;
    logic [AW-1:0] reqAddr_q;
    logic [TW-1:0] timer_q;
    logic          wrAck_q;
    logic [2:0]    rdAck_q;
    logic [63:0]   rdData_q;
    logic          err_q;
    logic [28:0]   ddramAddr_q;
    logic          ddramRd_q;
    logic          ddramWe_q;
    logic [63:0]   ddramDin_q;
    logic [7:0]    ddramBe_q;

    logic [2:0]    eligible_d;
    logic          grantValid_d;
    logic [1:0]    grantIdx_d;
    logic [AW-1:0] grantAddr_d;
    logic [1:0]    rrNext_d;

    // (base + k) mod 3 for base, k in 0..2
    function automatic logic [1:0] rotIdx(input logic [1:0] base, input logic [1:0] k);
        logic [2:0] s;
        s = {1'b0, base} + {1'b0, k};
        if (s >= 3'd3) s = s - 3'd3;
        return s[1:0];
    endfunction

    // A reader that is still holding its request during its own ack cycle has already
    // been served, so it is masked out to avoid a duplicate grant.
    assign eligible_d = rd_req_i & ~rdAck_q;

    // Round-robin pick: first eligible reader scanning upward from the rr pointer.
    always_comb begin
        grantValid_d = 1'b0;
        grantIdx_d   = rrPtr_q;
        for (int k = 0; k < 3; k++) begin
            if (!grantValid_d && eligible_d[rotIdx(rrPtr_q, 2'(k))]) begin
                grantValid_d = 1'b1;
                grantIdx_d   = rotIdx(rrPtr_q, 2'(k));
            end
        end
    end

    assign grantAddr_d = rd_addr_i[grantIdx_d*AW +: AW];
    assign rrNext_d    = (grantIdx_d == 2'd2) ? 2'd0 : grantIdx_d + 2'd1;

`ifdef PGM_DDR_LASTHIT_EN
    logic [2:0]    cacheValid_q;
    logic [AW-1:0] cacheAddr_q [3];
    logic [63:0]   cacheData_q [3];
    logic          hitValid_d;
    logic [1:0]    hitIdx_d;

    // Scan downward so the lowest-index hitting reader ends up selected.
    always_comb begin
        hitValid_d = 1'b0;
        hitIdx_d   = 2'd0;
        for (int i = 2; i >= 0; i--) begin
            if (eligible_d[i] && cacheValid_q[i] &&
                cacheAddr_q[i] == rd_addr_i[i*AW +: AW]) begin
                hitValid_d = 1'b1;
                hitIdx_d   = 2'(i);
            end
        end
    end
`endif

    // Arbiter FSM. Ack pulses default low every cycle; the command strobes stay up
    // until DDRAM drops waitrequest.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            rrPtr_q     <= 2'd0;
            grant_q     <= 2'd0;
            reqAddr_q   <= '0;
            timer_q     <= '0;
            wrAck_q     <= 1'b0;
            rdAck_q     <= 3'b000;
            rdData_q    <= 64'd0;
            err_q       <= 1'b0;
            ddramAddr_q <= 29'd0;
            ddramRd_q   <= 1'b0;
            ddramWe_q   <= 1'b0;
            ddramDin_q  <= 64'd0;
            ddramBe_q   <= 8'd0;
`ifdef PGM_DDR_LASTHIT_EN
            cacheValid_q <= 3'b000;
            for (int i = 0; i < 3; i++) begin
                cacheAddr_q[i] <= '0;
                cacheData_q[i] <= 64'd0;
            end
`endif
        end else begin
            wrAck_q <= 1'b0;
            rdAck_q <= 3'b000;
            case (state_q)
                IDLE: begin
                    if (wr_req_i && !wrAck_q) begin
                        ddramAddr_q <= BASE_WADDR + 29'(wr_addr_i);
                        ddramDin_q  <= wr_data_i;
                        ddramBe_q   <= wr_be_i;
                        ddramWe_q   <= 1'b1;
                        state_q     <= WR;
`ifdef PGM_DDR_LASTHIT_EN
                        // Written data may alias any cached word.
                        cacheValid_q <= 3'b000;
`endif
                    end
`ifdef PGM_DDR_LASTHIT_EN
                    else if (hitValid_d) begin
                        rdAck_q[hitIdx_d] <= 1'b1;
                        rdData_q          <= cacheData_q[hitIdx_d];
                    end
`endif
                    else if (grantValid_d) begin
                        grant_q     <= grantIdx_d;
                        reqAddr_q   <= grantAddr_d;
                        ddramAddr_q <= BASE_WADDR + 29'(grantAddr_d);
                        ddramRd_q   <= 1'b1;
                        rrPtr_q     <= rrNext_d;
                        state_q     <= RD_CMD;
                    end
                end
                WR: begin
                    if (!ddram_busy_i) begin
                        ddramWe_q <= 1'b0;
                        wrAck_q   <= 1'b1;
                        state_q   <= IDLE;
                    end
                end
                RD_CMD: begin
                    if (!ddram_busy_i) begin
                        ddramRd_q <= 1'b0;
                        timer_q   <= '0;
                        state_q   <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (ddram_dout_ready_i) begin
                        rdData_q         <= ddram_dout_i;
                        rdAck_q[grant_q] <= 1'b1;
                        state_q          <= IDLE;
`ifdef PGM_DDR_LASTHIT_EN
                        cacheValid_q[grant_q] <= 1'b1;
                        cacheAddr_q[grant_q]  <= reqAddr_q;
                        cacheData_q[grant_q]  <= ddram_dout_i;
`endif
                    end else if (timer_q == TIMEOUT_LAST) begin
                        // Give up after TIMEOUT cycles so the requester never hangs.
                        rdData_q         <= 64'hFFFF_FFFF_FFFF_FFFF;
                        rdAck_q[grant_q] <= 1'b1;
                        err_q            <= 1'b1;
                        state_q          <= IDLE;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign wr_ack_o         = wrAck_q;
    assign rd_ack_o         = rdAck_q;
    assign rd_data_o        = rdData_q;
    assign err_o            = err_q;
    assign ddram_addr_o     = ddramAddr_q;
    assign ddram_burstcnt_o = 4'd1;
    assign ddram_rd_o       = ddramRd_q;
    assign ddram_we_o       = ddramWe_q;
    assign ddram_din_o      = ddramDin_q;
    assign ddram_be_o       = ddramBe_q;

endmodule

// File: tb/tb_pgm_ddram_arbiter.sv
// tb_pgm_ddram_arbiter
// Self-checking bench for pgm_ddram_arbiter. Expected read results are pushed to a
// scoreboard queue when a request is driven and popped when rd_ack appears.
// A small DDRAM model answers accepted reads after respLat cycles when autoResp is set.
module tb_pgm_ddram_arbiter;

    localparam int          AW      = 25;
    localparam logic [28:0] BASE    = 29'h0600_0000;
    localparam int          TIMEOUT = 1023;

    logic            clk = 1'b0;
    logic            reset;
    logic            wrReq;
    logic [AW-1:0]   wrAddr;
    logic [63:0]     wrData;
    logic [7:0]      wrBe;
    logic            wrAck;
    logic [2:0]      rdReq;
    logic [3*AW-1:0] rdAddr;
    logic [2:0]      rdAck;
    logic [63:0]     rdData;
    logic            err;
    logic            busy;
    logic [63:0]     dout;
    logic            doutReady;
    logic [28:0]     dAddr;
    logic [3:0]      dBurst;
    logic            dRd;
    logic            dWe;
    logic [63:0]     dDin;
    logic [7:0]      dBe;

    int testsRun    = 0;
    int testsFailed = 0;
    bit autoResp    = 1'b0;
    int respLat     = 2;

    typedef struct {
        logic [1:0]  reader;
        logic [63:0] data;
    } exp_t;
    exp_t expQ[$];

    pgm_ddram_arbiter #(.AW(AW), .BASE_WADDR(BASE), .TIMEOUT(TIMEOUT)) dut (
        .clk_i(clk), .reset_i(reset),
        .wr_req_i(wrReq), .wr_addr_i(wrAddr), .wr_data_i(wrData), .wr_be_i(wrBe),
        .wr_ack_o(wrAck),
        .rd_req_i(rdReq), .rd_addr_i(rdAddr), .rd_ack_o(rdAck), .rd_data_o(rdData),
        .err_o(err),
        .ddram_busy_i(busy), .ddram_dout_i(dout), .ddram_dout_ready_i(doutReady),
        .ddram_addr_o(dAddr), .ddram_burstcnt_o(dBurst), .ddram_rd_o(dRd),
        .ddram_we_o(dWe), .ddram_din_o(dDin), .ddram_be_o(dBe)
    );

    always #5 clk = ~clk;

    // Contents of the modelled DDRAM word at a given address.
    function automatic logic [63:0] memWord(input logic [28:0] a);
        return {3'b000, a, 3'b101, a};
    endfunction

    // DDRAM read responder: a command visible with busy low at a negedge is accepted
    // on the following posedge; data comes back respLat cycles later.
    initial begin
        logic [28:0] capAddr;
        forever begin
            @(negedge clk);
            if (autoResp && dRd && !busy) begin
                capAddr = dAddr;
                repeat (respLat) @(negedge clk);
                dout      = memWord(capAddr);
                doutReady = 1'b1;
                @(negedge clk);
                doutReady = 1'b0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got running need finished");
        $fatal(1, "[TB] watchdog");
    end

    task automatic applyReset();
        @(negedge clk);
        reset = 1'b1; wrReq = 1'b0; rdReq = 3'b000; busy = 1'b0; doutReady = 1'b0;
        dout = 64'd0; wrAddr = '0; wrData = 64'd0; wrBe = 8'd0; rdAddr = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Waits (at negedges) for any rd_ack; reports the ack seen, cycles waited and
    // whether a DDRAM read command appeared in between. Performs no comparisons.
    task automatic waitRdAck(input int maxCycles, output logic [2:0] ack, output int cycles,
                             output bit sawRd);
        ack = 3'b000; cycles = 0; sawRd = 1'b0;
        while (cycles < maxCycles) begin
            @(negedge clk);
            cycles++;
            if (dRd) sawRd = 1'b1;
            if (rdAck != 3'b000) begin
                ack = rdAck;
                break;
            end
        end
    endtask

    task automatic test_reset();
        applyReset();
        testsRun += 6;
        if (rdAck !== 3'b000) begin testsFailed++; $display("[TB] FAIL reset_rd_ack got %b need 000", rdAck); end
        if (wrAck !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_wr_ack got %b need 0", wrAck); end
        if ({dRd, dWe, err} !== 3'b000) begin testsFailed++; $display("[TB] FAIL reset_strobes got %b need 000", {dRd, dWe, err}); end
        if (rdData !== 64'd0) begin testsFailed++; $display("[TB] FAIL reset_rd_data got %h need 0", rdData); end
        if ({dAddr, dDin, dBe} !== '0) begin testsFailed++; $display("[TB] FAIL reset_ddram_out got %h/%h/%h need 0", dAddr, dDin, dBe); end
        if (dBurst !== 4'd1) begin testsFailed++; $display("[TB] FAIL burstcnt got %0d need 1", dBurst); end
    endtask

    task automatic test_single_read();
        logic [2:0] ack; int cyc; bit sawRd; exp_t e;
        applyReset();
        autoResp = 1'b0;
        @(negedge clk);
        rdAddr[0*AW +: AW] = AW'(32'h10);
        rdReq = 3'b001;
        expQ.push_back('{reader: 2'd0, data: 64'h1122_3344_5566_7788});
        @(negedge clk);
        testsRun += 2;
        if (dRd !== 1'b1) begin testsFailed++; $display("[TB] FAIL grant_to_rd got %b need 1", dRd); end
        if (dAddr !== 29'h0600_0010) begin testsFailed++; $display("[TB] FAIL single_addr got %h need 06000010", dAddr); end
        repeat (4) @(negedge clk);
        dout = 64'h1122_3344_5566_7788;
        doutReady = 1'b1;
        @(negedge clk);
        doutReady = 1'b0;
        ack = rdAck;
        rdReq = 3'b000;
        e = expQ.pop_front();
        testsRun += 2;
        if (ack !== (3'b001 << e.reader)) begin testsFailed++; $display("[TB] FAIL single_ack got %b need %b", ack, 3'b001 << e.reader); end
        if (rdData !== e.data) begin testsFailed++; $display("[TB] FAIL single_data got %h need %h", rdData, e.data); end
        waitRdAck(5, ack, cyc, sawRd);
        testsRun++;
        if (ack !== 3'b000 || sawRd) begin testsFailed++; $display("[TB] FAIL single_no_repeat got ack %b rd %b need 000 0", ack, sawRd); end
    endtask

    task automatic test_round_robin();
        logic [2:0] ack; int cyc; bit sawRd; exp_t e;
        applyReset();
        autoResp = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) rdAddr[i*AW +: AW] = AW'(32'h100 + i);
        rdReq = 3'b111;
        for (int n = 0; n < 6; n++)
            expQ.push_back('{reader: 2'(n % 3), data: memWord(BASE + 29'(32'h100 + n % 3))});
        for (int n = 0; n < 6; n++) begin
            waitRdAck(30, ack, cyc, sawRd);
            if (n == 5) rdReq = 3'b000;
            e = expQ.pop_front();
            testsRun += 2;
            if (ack !== (3'b001 << e.reader)) begin testsFailed++; $display("[TB] FAIL rr_order_%0d got %b need %b", n, ack, 3'b001 << e.reader); end
            if (rdData !== e.data) begin testsFailed++; $display("[TB] FAIL rr_data_%0d got %h need %h", n, rdData, e.data); end
        end
    endtask

    task automatic test_write_priority();
        logic [2:0] ack; int cyc; bit sawRd; exp_t e; int weCount; bit rdDuringWr;
        applyReset();
        autoResp = 1'b1;
        @(negedge clk);
        wrAddr = AW'(32'h1_2345); wrData = 64'hDEAD_BEEF_0123_4567; wrBe = 8'hA5;
        wrReq = 1'b1; busy = 1'b1;
        rdAddr[1*AW +: AW] = AW'(32'h200);
        rdReq = 3'b010;
        expQ.push_back('{reader: 2'd1, data: memWord(BASE + 29'h200)});
        weCount = 0; rdDuringWr = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (dWe) weCount++;
            if (dRd || rdAck != 3'b000) rdDuringWr = 1'b1;
            if (k == 1) begin
                testsRun += 3;
                if (dAddr !== 29'h0601_2345) begin testsFailed++; $display("[TB] FAIL wr_addr got %h need 06012345", dAddr); end
                if (dDin !== 64'hDEAD_BEEF_0123_4567) begin testsFailed++; $display("[TB] FAIL wr_din got %h need deadbeef01234567", dDin); end
                if (dBe !== 8'hA5) begin testsFailed++; $display("[TB] FAIL wr_be got %h need a5", dBe); end
            end
            if (k == 4) busy = 1'b0;
        end
        @(negedge clk);
        testsRun += 3;
        if (weCount !== 4) begin testsFailed++; $display("[TB] FAIL we_hold got %0d need 4", weCount); end
        if ({dWe, wrAck} !== 2'b01) begin testsFailed++; $display("[TB] FAIL wr_done got we %b ack %b need 0 1", dWe, wrAck); end
        if (rdDuringWr) begin testsFailed++; $display("[TB] FAIL rd_during_wr got 1 need 0"); end
        wrReq = 1'b0;
        waitRdAck(30, ack, cyc, sawRd);
        rdReq = 3'b000;
        e = expQ.pop_front();
        testsRun += 2;
        if (ack !== (3'b001 << e.reader)) begin testsFailed++; $display("[TB] FAIL wr_then_rd_ack got %b need %b", ack, 3'b001 << e.reader); end
        if (rdData !== e.data) begin testsFailed++; $display("[TB] FAIL wr_then_rd_data got %h need %h", rdData, e.data); end
    endtask

    task automatic test_timeout();
        logic [2:0] ack; int cyc; bit sawRd; exp_t e;
        applyReset();
        autoResp = 1'b0;
        @(negedge clk);
        rdAddr[2*AW +: AW] = AW'(32'h20);
        rdReq = 3'b100;
        expQ.push_back('{reader: 2'd2, data: 64'hFFFF_FFFF_FFFF_FFFF});
        @(negedge clk);
        waitRdAck(TIMEOUT + 20, ack, cyc, sawRd);
        rdReq = 3'b000;
        e = expQ.pop_front();
        testsRun += 4;
        if (ack !== (3'b001 << e.reader)) begin testsFailed++; $display("[TB] FAIL timeout_ack got %b need %b", ack, 3'b001 << e.reader); end
        if (cyc !== TIMEOUT + 1) begin testsFailed++; $display("[TB] FAIL timeout_cycles got %0d need %0d", cyc, TIMEOUT + 1); end
        if (rdData !== e.data) begin testsFailed++; $display("[TB] FAIL timeout_data got %h need %h", rdData, e.data); end
        if (err !== 1'b1) begin testsFailed++; $display("[TB] FAIL timeout_err got %b need 1", err); end
        autoResp = 1'b1;
        @(negedge clk);
        rdAddr[0*AW +: AW] = AW'(32'h21);
        rdReq = 3'b001;
        waitRdAck(30, ack, cyc, sawRd);
        rdReq = 3'b000;
        testsRun += 2;
        if (rdData !== memWord(BASE + 29'h21)) begin testsFailed++; $display("[TB] FAIL post_timeout_data got %h need %h", rdData, memWord(BASE + 29'h21)); end
        if (err !== 1'b1) begin testsFailed++; $display("[TB] FAIL err_sticky got %b need 1", err); end
        applyReset();
        testsRun++;
        if (err !== 1'b0) begin testsFailed++; $display("[TB] FAIL err_cleared got %b need 0", err); end
    endtask

    task automatic test_reset_midflight();
        logic [2:0] ack; int cyc; bit sawRd; logic [2:0] ackSeen; exp_t e;
        applyReset();
        autoResp = 1'b0;
        @(negedge clk);
        rdAddr[0*AW +: AW] = AW'(32'h30);
        rdReq = 3'b001;
        @(negedge clk);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        rdReq = 3'b000;
        @(negedge clk);
        reset = 1'b0;
        dout = 64'h5555_AAAA_5555_AAAA;
        doutReady = 1'b1;
        testsRun += 2;
        if ({dRd, dWe, err, wrAck, rdAck} !== 7'd0) begin testsFailed++; $display("[TB] FAIL midreset_strobes got %b need 0", {dRd, dWe, err, wrAck, rdAck}); end
        if ({rdData, dAddr, dDin, dBe} !== '0) begin testsFailed++; $display("[TB] FAIL midreset_regs got %h/%h need 0", rdData, dAddr); end
        ackSeen = 3'b000;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            doutReady = 1'b0;
            ackSeen |= rdAck;
        end
        testsRun += 2;
        if (ackSeen !== 3'b000) begin testsFailed++; $display("[TB] FAIL late_ready_ack got %b need 000", ackSeen); end
        if (rdData !== 64'd0) begin testsFailed++; $display("[TB] FAIL late_ready_data got %h need 0", rdData); end
        autoResp = 1'b1;
        rdAddr[1*AW +: AW] = AW'(32'h40);
        rdReq = 3'b010;
        expQ.push_back('{reader: 2'd1, data: memWord(BASE + 29'h40)});
        waitRdAck(30, ack, cyc, sawRd);
        rdReq = 3'b000;
        e = expQ.pop_front();
        testsRun += 2;
        if (ack !== (3'b001 << e.reader)) begin testsFailed++; $display("[TB] FAIL after_reset_ack got %b need %b", ack, 3'b001 << e.reader); end
        if (rdData !== e.data) begin testsFailed++; $display("[TB] FAIL after_reset_data got %h need %h", rdData, e.data); end
    endtask

    task automatic test_lasthit();
        logic [2:0] ack; int cyc; bit sawRd; exp_t e; int wcyc;
        applyReset();
        autoResp = 1'b1;
        @(negedge clk);
        rdAddr[2*AW +: AW] = AW'(32'h50);
        rdReq = 3'b100;
        expQ.push_back('{reader: 2'd2, data: memWord(BASE + 29'h50)});
        waitRdAck(30, ack, cyc, sawRd);
        rdReq = 3'b000;
        e = expQ.pop_front();
        testsRun += 2;
        if (ack !== 3'b100 || !sawRd) begin testsFailed++; $display("[TB] FAIL lh_fill got ack %b rd %b need 100 1", ack, sawRd); end
        if (rdData !== e.data) begin testsFailed++; $display("[TB] FAIL lh_fill_data got %h need %h", rdData, e.data); end
        @(negedge clk);
        rdReq = 3'b100;
        expQ.push_back('{reader: 2'd2, data: memWord(BASE + 29'h50)});
        waitRdAck(30, ack, cyc, sawRd);
        rdReq = 3'b000;
        e = expQ.pop_front();
        testsRun += 2;
        if (rdData !== e.data || ack !== 3'b100) begin testsFailed++; $display("[TB] FAIL lh_repeat got ack %b data %h need 100 %h", ack, rdData, e.data); end
`ifdef PGM_DDR_LASTHIT_EN
        if (sawRd || cyc !== 1) begin testsFailed++; $display("[TB] FAIL lh_hit got rd %b cycles %0d need 0 1", sawRd, cyc); end
`else
        if (!sawRd) begin testsFailed++; $display("[TB] FAIL no_cache_repeat got rd %b need 1", sawRd); end
`endif
        @(negedge clk);
        wrAddr = AW'(32'h77); wrData = 64'h0123; wrBe = 8'hFF; wrReq = 1'b1;
        wcyc = 0;
        while (!wrAck && wcyc < 20) begin @(negedge clk); wcyc++; end
        wrReq = 1'b0;
        testsRun++;
        if (wrAck !== 1'b1) begin testsFailed++; $display("[TB] FAIL lh_write_ack got %b need 1", wrAck); end
        @(negedge clk);
        rdReq = 3'b100;
        waitRdAck(30, ack, cyc, sawRd);
        rdReq = 3'b000;
        testsRun++;
        if (!sawRd || ack !== 3'b100) begin testsFailed++; $display("[TB] FAIL lh_after_write got rd %b ack %b need 1 100", sawRd, ack); end
    endtask

    initial begin
        reset = 1'b1; wrReq = 1'b0; rdReq = 3'b000; busy = 1'b0; doutReady = 1'b0;
        dout = 64'd0; wrAddr = '0; wrData = 64'd0; wrBe = 8'd0; rdAddr = '0;
        test_reset();
        test_single_read();
        test_round_robin();
        test_write_priority();
        test_timeout();
        test_reset_midflight();
        test_lasthit();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
